controlador_juego: RTL and testbench

Sequencer for the 3×3 tic-tac-toe board. It owns the nine 2-bit cell registers and alternates turns between player 1 and player 2, accepting one move per turn through a pulse interface. It enforces a per-turn timeout by auto-placing the current player's mark, and declares the winner or a draw. It sits between the input decoder (buttons/switches) and the board display and end-of-game logic.

---
 rtl/controlador_juego.sv | 145 ++++++++++++++
 tb/tb_controlador_juego.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_juego.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, alternates players, applies
// per-turn timeout auto-moves and decides win or draw.
module controlador_juego #(
    parameter int unsigned CICLOS_TURNO = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic        movValido,
    input  logic [3:0]  movPos,
    output logic [17:0] tablero,
    output logic [1:0]  jugadorActual,
    output logic [1:0]  ganador,
    output logic        juegoFinalizado,
    output logic        movRechazado,
    output logic [15:0] tiempoRestante
);

    typedef enum logic [2:0] {REPOSO, TURNO_J1, TURNO_J2, VERIFICA, FIN} estado_t;

    localparam logic [15:0] RECARGA = 16'(CICLOS_TURNO - 1);
    localparam logic [1:0]  COD_J1  = 2'b01;
    localparam logic [1:0]  COD_J2  = 2'b10;
    localparam logic [1:0]  EMPATE  = 2'b11;

    localparam int LINEAS [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    estado_t     estado_q;
    logic [17:0] tablero_q, tablero_d;
    logic [1:0]  jugador_q, ganador_q, ultimo_q;
    logic        fin_q, rechazo_q;
    logic [15:0] tiempo_q;

    logic [1:0]  cod_turno;
    logic [1:0]  celda_obj;
    logic        pos_ok, legal, gana, lleno;
    logic [3:0]  libre, destino;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        cod_turno = (estado_q == TURNO_J2) ? COD_J2 : COD_J1;
        pos_ok    = (movPos <= 4'd8);
        celda_obj = 2'b00;
        for (int k = 0; k < 9; k++) begin
            if (movPos == 4'(k)) celda_obj = tablero_q[2*k +: 2];
        end
        legal = movValido && pos_ok && (celda_obj == 2'b00);

        // Scan downwards so the lowest-index empty cell is the one kept.
        libre = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (tablero_q[2*k +: 2] == 2'b00) libre = 4'(k);
        end
        destino = legal ? movPos : libre;

        tablero_d = tablero_q;
        for (int k = 0; k < 9; k++) begin
            if (destino == 4'(k)) tablero_d[2*k +: 2] = cod_turno;
        end

        gana = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (tablero_q[2*LINEAS[l][0] +: 2] == ultimo_q &&
                tablero_q[2*LINEAS[l][1] +: 2] == ultimo_q &&
                tablero_q[2*LINEAS[l][2] +: 2] == ultimo_q)
                gana = 1'b1;
        end

        lleno = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (tablero_q[2*k +: 2] == 2'b00) lleno = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            tablero_q <= '0;
            jugador_q <= 2'b00;
            ganador_q <= 2'b00;
            ultimo_q  <= 2'b00;
            fin_q     <= 1'b0;
            rechazo_q <= 1'b0;
            tiempo_q  <= '0;
        end else begin
            rechazo_q <= 1'b0;
            case (estado_q)
                REPOSO, FIN: begin
                    if (inicio) begin
                        estado_q  <= TURNO_J1;
                        tablero_q <= '0;
                        ganador_q <= 2'b00;
                        jugador_q <= COD_J1;
                        fin_q     <= 1'b0;
                        tiempo_q  <= RECARGA;
                    end
                end
                TURNO_J1, TURNO_J2: begin
                    // A legal move takes priority over the timeout auto-move.
                    if (legal || tiempo_q == 16'd0) begin
                        estado_q  <= VERIFICA;
                        tablero_q <= tablero_d;
                        ultimo_q  <= cod_turno;
                        jugador_q <= 2'b00;
                        tiempo_q  <= '0;
                    end else begin
                        tiempo_q  <= tiempo_q - 16'd1;
                    end
                    if (movValido && !legal) rechazo_q <= 1'b1;
                end
                VERIFICA: begin
                    if (gana) begin
                        estado_q  <= FIN;
                        ganador_q <= ultimo_q;
                        fin_q     <= 1'b1;
                    end else if (lleno) begin
                        estado_q  <= FIN;
                        ganador_q <= EMPATE;
                        fin_q     <= 1'b1;
                    end else begin
                        estado_q  <= (ultimo_q == COD_J1) ? TURNO_J2 : TURNO_J1;
                        jugador_q <= (ultimo_q == COD_J1) ? COD_J2 : COD_J1;
                        tiempo_q  <= RECARGA;
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign tablero         = tablero_q;
    assign jugadorActual   = jugador_q;
    assign ganador         = ganador_q;
    assign juegoFinalizado = fin_q;
    assign movRechazado    = rechazo_q;
    assign tiempoRestante  = tiempo_q;

endmodule

// File: tb/tb_controlador_juego.sv
// Self-checking bench for controlador_juego: fixed vector table, directed
// corner sequences and random play against a board-level reference model.
module tb_controlador_juego;

    localparam int C = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic        movValido = 1'b0;
    logic [3:0]  movPos = 4'd0;
    logic [17:0] tablero;
    logic [1:0]  jugadorActual, ganador;
    logic        juegoFinalizado, movRechazado;
    logic [15:0] tiempoRestante;

    controlador_juego #(.CICLOS_TURNO(C)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .movValido(movValido),
        .movPos(movPos), .tablero(tablero), .jugadorActual(jugadorActual),
        .ganador(ganador), .juegoFinalizado(juegoFinalizado),
        .movRechazado(movRechazado), .tiempoRestante(tiempoRestante)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 turn, 2 verify, 3 finished.
    localparam int LIN [8][3] = '{
        '{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}
    };
    int m_modo, m_jug, m_ult, m_t, m_gan, m_rej;
    int m_tab [9];

    task automatic model_reset();
        m_modo = 0; m_jug = 0; m_ult = 0; m_t = 0; m_gan = 0; m_rej = 0;
        for (int k = 0; k < 9; k++) m_tab[k] = 0;
    endtask

    task automatic model_step(input logic ini, input logic mv, input logic [3:0] pos);
        int p, dest;
        bit legal, win, full;
        p = int'(pos);
        m_rej = 0;
        if (m_modo == 0 || m_modo == 3) begin
            if (ini) begin
                for (int k = 0; k < 9; k++) m_tab[k] = 0;
                m_modo = 1; m_jug = 1; m_t = C - 1; m_gan = 0;
            end
        end else if (m_modo == 1) begin
            legal = mv && p <= 8 && m_tab[p <= 8 ? p : 0] == 0;
            if (mv && !legal) m_rej = 1;
            if (legal || m_t == 0) begin
                dest = p;
                if (!legal) begin
                    dest = -1;
                    for (int k = 0; k < 9; k++) if (dest < 0 && m_tab[k] == 0) dest = k;
                end
                m_tab[dest] = m_jug;
                m_ult = m_jug;
                m_modo = 2;
            end else begin
                m_t = m_t - 1;
            end
        end else begin
            win = 0;
            for (int l = 0; l < 8; l++)
                if (m_tab[LIN[l][0]] == m_ult && m_tab[LIN[l][1]] == m_ult && m_tab[LIN[l][2]] == m_ult)
                    win = 1;
            full = 1;
            for (int k = 0; k < 9; k++) if (m_tab[k] == 0) full = 0;
            if (win) begin
                m_modo = 3; m_gan = m_ult;
            end else if (full) begin
                m_modo = 3; m_gan = 3;
            end else begin
                m_modo = 1; m_jug = 3 - m_ult; m_t = C - 1;
            end
        end
    endtask

    function automatic logic [39:0] model_vec();
        logic [17:0] t;
        for (int k = 0; k < 9; k++) t[2*k +: 2] = 2'(m_tab[k]);
        return {t, (m_modo == 1) ? 2'(m_jug) : 2'b00, 2'(m_gan), m_modo == 3,
                m_rej != 0, (m_modo == 1) ? 16'(m_t) : 16'd0};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {tablero, jugadorActual, ganador, juegoFinalizado, movRechazado, tiempoRestante};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got tab=%h jug=%b gan=%b fin=%b rej=%b t=%0d, expected tab=%h jug=%b gan=%b fin=%b rej=%b t=%0d",
                     name, $time, act[39:22], act[21:20], act[19:18], act[17], act[16], act[15:0],
                     exp[39:22], exp[21:20], exp[19:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic step(input logic ini, input logic mv, input logic [3:0] pos);
        @(negedge clk);
        inicio = ini; movValido = mv; movPos = pos;
        @(posedge clk);
        model_step(ini, mv, pos);
        #1;
        inicio = 1'b0; movValido = 1'b0;
    endtask

    task automatic mstep(input logic ini, input logic mv, input logic [3:0] pos);
        step(ini, mv, pos);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        ini, mv;
        logic [3:0]  pos;
        logic [17:0] tab;
        logic [1:0]  jug, gan;
        logic        fin, rej;
        logic [15:0] t;
    } vec_t;
    vec_t tabla [15];

    initial begin
        // J1 wins on the top row; J2 gets two rejections along the way.
        tabla[0]  = '{1, 0, 0, 18'h000, 2'd1, 2'd0, 0, 0, 16'd14};
        tabla[1]  = '{0, 1, 0, 18'h001, 2'd0, 2'd0, 0, 0, 16'd0};
        tabla[2]  = '{0, 0, 0, 18'h001, 2'd2, 2'd0, 0, 0, 16'd14};
        tabla[3]  = '{0, 1, 0, 18'h001, 2'd2, 2'd0, 0, 1, 16'd13};
        tabla[4]  = '{0, 1, 9, 18'h001, 2'd2, 2'd0, 0, 1, 16'd12};
        tabla[5]  = '{0, 1, 3, 18'h081, 2'd0, 2'd0, 0, 0, 16'd0};
        tabla[6]  = '{0, 0, 0, 18'h081, 2'd1, 2'd0, 0, 0, 16'd14};
        tabla[7]  = '{0, 1, 1, 18'h085, 2'd0, 2'd0, 0, 0, 16'd0};
        tabla[8]  = '{0, 0, 0, 18'h085, 2'd2, 2'd0, 0, 0, 16'd14};
        tabla[9]  = '{0, 1, 4, 18'h285, 2'd0, 2'd0, 0, 0, 16'd0};
        tabla[10] = '{0, 0, 0, 18'h285, 2'd1, 2'd0, 0, 0, 16'd14};
        tabla[11] = '{0, 1, 2, 18'h295, 2'd0, 2'd0, 0, 0, 16'd0};
        tabla[12] = '{0, 0, 0, 18'h295, 2'd0, 2'd1, 1, 0, 16'd0};
        tabla[13] = '{0, 1, 5, 18'h295, 2'd0, 2'd1, 1, 0, 16'd0};
        tabla[14] = '{1, 0, 0, 18'h000, 2'd1, 2'd0, 0, 0, 16'd0 + 16'd14};

        do_reset();
        check("reset", dut_vec(), 40'h0);
        for (int i = 0; i < 15; i++) begin
            step(tabla[i].ini, tabla[i].mv, tabla[i].pos);
            check($sformatf("tabla[%0d]", i), dut_vec(),
                  {tabla[i].tab, tabla[i].jug, tabla[i].gan, tabla[i].fin, tabla[i].rej, tabla[i].t});
        end

        // Timeouts: J1 auto-places in cell 0, then J2 in cell 1.
        do_reset();
        mstep(1, 0, 0);
        repeat (15) mstep(0, 0, 0);
        check("auto_j1", {22'h0, tablero}, {22'h0, 18'h001});
        mstep(0, 0, 0);
        check("turno_j2", {38'h0, jugadorActual}, {38'h0, 2'b10});
        repeat (15) mstep(0, 0, 0);
        check("auto_j2", {22'h0, tablero}, {22'h0, 18'h009});

        // Legal move on the timer=0 cycle lands at its own position.
        do_reset();
        mstep(1, 0, 0);
        repeat (14) mstep(0, 0, 0);
        check("timer_cero", {24'h0, tiempoRestante}, 40'h0);
        mstep(0, 1, 5);
        check("mov_en_cero", {22'h0, tablero}, {22'h0, 18'h400});

        // Draw: full board, no line.
        do_reset();
        mstep(1, 0, 0);
        foreach (tabla[i]) if (i < 9) begin
            logic [3:0] orden [9];
            orden = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
            mstep(0, 1, orden[i]);
            mstep(0, 0, 0);
        end
        check("empate", {38'h0, ganador}, {38'h0, 2'b11});
        check("empate_fin", {39'h0, juegoFinalizado}, {39'h0, 1'b1});

        // Asynchronous reset in the middle of a game.
        do_reset();
        mstep(1, 0, 0);
        mstep(0, 1, 4);
        mstep(0, 0, 0);
        #3 rst_n = 1'b0;
        #1 check("reset_async", dut_vec(), 40'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            mstep($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 10)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
